// File: rtl/cabac_pkg.sv
// Shared CABAC constants and types.
//   WIN_BITS    : window width / largest per-cycle consume
//   BUF_BITS    : shift-buffer capacity in bits
//   MAX_CONSUME : largest legal consume_n
//   consume_t   : consume-count type, also used by the decoder core for numBits
//   cnt_t       : buffered-bit count, 0..BUF_BITS
package cabac_pkg;
    localparam int WIN_BITS    = 16;
    localparam int BUF_BITS    = 32;
    localparam int MAX_CONSUME = 16;

    typedef logic [4:0] consume_t;
    typedef logic [5:0] cnt_t;
endpackage

// File: rtl/cabac_bit_feeder_if.sv
// Upstream slice-data byte stream, valid/ready handshake.
//   byte_in    : data byte, MSB is the earliest bitstream bit
//   byte_valid : byte_in is valid
//   byte_ready : sink accepts a byte this cycle
interface cabac_bit_feeder_if;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_ready;

    modport master (output byte_in, output byte_valid, input byte_ready);
    modport slave  (input byte_in, input byte_valid, output byte_ready);
endinterface

// File: rtl/cabac_bit_buffer.sv
// Combinational next-state datapath of the bit feeder: consume, then align,
// then byte insertion, all from the registered buffer and count.
//   buf_q/cnt_q : registered buffer (left-aligned) and bit count
//   consume_n   : bits consumed this cycle
//   align       : drop bits up to the next byte boundary after consume
//   ins_en      : a byte is accepted this cycle
//   ins_byte    : accepted byte
//   buf_d/cnt_d : next buffer and count
//   adv         : bits retired this cycle (consume + align)
//   illegal     : consume request rejected
module cabac_bit_buffer
    import cabac_pkg::*;
(
    input  logic [BUF_BITS-1:0] buf_q,
    input  cnt_t                cnt_q,
    input  consume_t            consume_n,
    input  logic                align,
    input  logic                ins_en,
    input  logic [7:0]          ins_byte,
    output logic [BUF_BITS-1:0] buf_d,
    output cnt_t                cnt_d,
    output logic [4:0]          adv,
    output logic                illegal
);
    logic [BUF_BITS-1:0] b1, b2, ins;
    cnt_t                c1, c2;
    logic [2:0]          d;

    always_comb begin
        illegal = (consume_n > consume_t'(MAX_CONSUME)) || ({1'b0, consume_n} > cnt_q);

        // A rejected consume leaves the state untouched, but align and
        // ingest still operate on the unchanged count.
        c1 = illegal ? cnt_q : cnt_q - {1'b0, consume_n};
        b1 = illegal ? buf_q : buf_q << consume_n;

        // Count is a multiple of 8 exactly when the next bit is byte aligned.
        d  = align ? c1[2:0] : 3'd0;
        b2 = b1 << d;
        c2 = c1 - {3'b0, d};

        // byte_ready guarantees c2 <= 24, so the byte always fits.
        ins   = {ins_byte, {(BUF_BITS-8){1'b0}}} >> c2;
        buf_d = ins_en ? (b2 | ins) : b2;
        cnt_d = ins_en ? c2 + 6'd8 : c2;

        adv = (illegal ? 5'd0 : consume_n) + {2'b0, d};
    end
endmodule

// File: rtl/cabac_bit_feeder.sv
// CABAC bitstream front-end. Buffers slice-data bytes MSB first and presents
// the next 16 unconsumed bits to the arithmetic decoder core.
//   clk, reset    : clock, async active-high reset
//   byte_if       : upstream byte handshake (slave side)
//   consume_n     : bits consumed by the core this cycle (0..16)
//   align         : discard to next byte boundary after consume
//   flush         : synchronous clear, highest priority
//   win           : next 16 bits, win[15] oldest
//   win_valid     : at least 16 bits buffered
//   bit_count     : buffered bits, 0..32
//   bits_consumed : running consumed-bit total, wraps mod 2^24
//   err           : sticky illegal-consume flag, cleared by flush
module cabac_bit_feeder
    import cabac_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    cabac_bit_feeder_if.slave   byte_if,
    input  consume_t            consume_n,
    input  logic                align,
    input  logic                flush,
    output logic [WIN_BITS-1:0] win,
    output logic                win_valid,
    output cnt_t                bit_count,
    output logic [23:0]         bits_consumed,
    output logic                err
);
    logic [BUF_BITS-1:0] buf_q, buf_d;
    cnt_t                cnt_q, cnt_d;
    logic [4:0]          adv;
    logic                illegal;
    logic                accept;

    // Ready depends only on the registered count (and flush), never on this
    // cycle's consume, so there is no combinational path from the core.
    assign byte_if.byte_ready = (cnt_q <= cnt_t'(BUF_BITS - 8)) && !flush;
    assign accept             = byte_if.byte_valid && byte_if.byte_ready;

    cabac_bit_buffer u_buf (
        .buf_q     (buf_q),
        .cnt_q     (cnt_q),
        .consume_n (consume_n),
        .align     (align),
        .ins_en    (accept),
        .ins_byte  (byte_if.byte_in),
        .buf_d     (buf_d),
        .cnt_d     (cnt_d),
        .adv       (adv),
        .illegal   (illegal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_q         <= '0;
            cnt_q         <= '0;
            bits_consumed <= '0;
            err           <= 1'b0;
        end else if (flush) begin
            buf_q         <= '0;
            cnt_q         <= '0;
            bits_consumed <= '0;
            err           <= 1'b0;
        end else begin
            buf_q         <= buf_d;
            cnt_q         <= cnt_d;
            bits_consumed <= bits_consumed + {19'b0, adv};
            err           <= err | illegal;
        end
    end

    // Priming and running states both reduce to "16 or more bits buffered";
    // a starved upstream in steady state simply drops win_valid again.
    assign win       = buf_q[BUF_BITS-1 -: WIN_BITS];
    assign win_valid = (cnt_q >= cnt_t'(WIN_BITS));
    assign bit_count = cnt_q;
endmodule

// File: tb/tb_cabac_bit_feeder.sv
module tb_cabac_bit_feeder;
    import cabac_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    consume_t    consume_n = '0;
    logic        align = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] win;
    logic        win_valid;
    cnt_t        bit_count;
    logic [23:0] bits_consumed;
    logic        err;
    int          nt = 0;
    int          nf = 0;

    cabac_bit_feeder_if bif ();

    cabac_bit_feeder dut (
        .clk           (clk),
        .reset         (reset),
        .byte_if       (bif),
        .consume_n     (consume_n),
        .align         (align),
        .flush         (flush),
        .win           (win),
        .win_valid     (win_valid),
        .bit_count     (bit_count),
        .bits_consumed (bits_consumed),
        .err           (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nt++;
        if (act !== exp) begin
            nf++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bif.byte_valid = 1'b0;
        bif.byte_in    = 8'h00;
        consume_n      = '0;
        align          = 1'b0;
        flush          = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        #12;
        chk("rst_win", 32'(win), 32'h0);
        chk("rst_win_valid", 32'(win_valid), 32'h0);
        chk("rst_bit_count", 32'(bit_count), 32'h0);
        chk("rst_byte_ready", 32'(bif.byte_ready), 32'h1);
        chk("rst_bits_consumed", 32'(bits_consumed), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_prime();
        bif.byte_valid = 1'b1;
        bif.byte_in    = 8'h8C;
        step();
        chk("prime1_win", 32'(win), 32'h8C00);
        chk("prime1_win_valid", 32'(win_valid), 32'h0);
        bif.byte_in = 8'hD1;
        step();
        bif.byte_valid = 1'b0;
        chk("prime2_win", 32'(win), 32'h8CD1);
        chk("prime2_win_valid", 32'(win_valid), 32'h1);
        chk("prime2_bit_count", 32'(bit_count), 32'd16);
    endtask

    task automatic test_consume_ingest();
        bif.byte_valid = 1'b1;
        bif.byte_in    = 8'h5A;
        consume_n      = 5'd3;
        step();
        idle_inputs();
        chk("ci_win", 32'(win), 32'h668A);
        chk("ci_bit_count", 32'(bit_count), 32'd21);
        chk("ci_bits_consumed", 32'(bits_consumed), 32'd3);
    endtask

    task automatic test_align();
        align = 1'b1;
        step();
        idle_inputs();
        chk("al_bit_count", 32'(bit_count), 32'd16);
        chk("al_win", 32'(win), 32'hD15A);
        chk("al_bits_consumed", 32'(bits_consumed), 32'd8);
        // already aligned: no-op
        align = 1'b1;
        step();
        idle_inputs();
        chk("al_noop_bit_count", 32'(bit_count), 32'd16);
        chk("al_noop_win", 32'(win), 32'hD15A);
    endtask

    task automatic test_flush_with_byte();
        flush          = 1'b1;
        bif.byte_valid = 1'b1;
        bif.byte_in    = 8'hEE;
        #1;
        chk("fl_ready_low", 32'(bif.byte_ready), 32'h0);
        step();
        idle_inputs();
        chk("fl_bit_count", 32'(bit_count), 32'd0);
        chk("fl_bits_consumed", 32'(bits_consumed), 32'd0);
        chk("fl_win", 32'(win), 32'h0);
    endtask

    task automatic test_backpressure();
        logic [7:0] bytes [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        int acc = 0;
        bif.byte_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bif.byte_in = (acc < 4) ? bytes[acc] : 8'hFF;
            #1;
            if (bif.byte_ready) acc++;
            step();
        end
        idle_inputs();
        chk("bp_accepts", 32'(acc), 32'd4);
        chk("bp_bit_count", 32'(bit_count), 32'd32);
        chk("bp_ready_full", 32'(bif.byte_ready), 32'h0);
        chk("bp_win", 32'(win), 32'hA1B2);
        consume_n = 5'd16;
        step();
        idle_inputs();
        chk("bp_ready_back", 32'(bif.byte_ready), 32'h1);
        chk("bp_bit_count2", 32'(bit_count), 32'd16);
        chk("bp_win2", 32'(win), 32'hC3D4);
        chk("bp_bits_consumed", 32'(bits_consumed), 32'd16);
    endtask

    task automatic test_illegal();
        consume_n = 5'd11;
        step();
        idle_inputs();
        chk("il_pre_count", 32'(bit_count), 32'd5);
        chk("il_pre_win", 32'(win), 32'hA000);
        chk("il_pre_win_valid", 32'(win_valid), 32'h0);
        consume_n = 5'd7;
        step();
        idle_inputs();
        chk("il_count", 32'(bit_count), 32'd5);
        chk("il_win", 32'(win), 32'hA000);
        chk("il_bits_consumed", 32'(bits_consumed), 32'd27);
        chk("il_err", 32'(err), 32'h1);
        step();
        chk("il_err_sticky", 32'(err), 32'h1);
        // illegal consume plus align: align uses the unchanged count of 5
        consume_n = 5'd7;
        align     = 1'b1;
        step();
        idle_inputs();
        chk("il_align_count", 32'(bit_count), 32'd0);
        chk("il_align_bits_consumed", 32'(bits_consumed), 32'd32);
        flush = 1'b1;
        step();
        idle_inputs();
        chk("il_flush_err", 32'(err), 32'h0);
        chk("il_flush_count", 32'(bit_count), 32'd0);
    endtask

    task automatic test_over_max_consume();
        logic [7:0] bytes [3] = '{8'h12, 8'h34, 8'h56};
        bif.byte_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bif.byte_in = bytes[i];
            step();
        end
        idle_inputs();
        consume_n = 5'd17;
        step();
        idle_inputs();
        chk("ov_count", 32'(bit_count), 32'd24);
        chk("ov_err", 32'(err), 32'h1);
        chk("ov_win", 32'(win), 32'h1234);
        flush = 1'b1;
        step();
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [10] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89,
                                   8'hAB, 8'hCD, 8'hEF, 8'h10, 8'h32};
        bif.byte_valid = 1'b1;
        bif.byte_in    = bytes[0];
        step();
        bif.byte_in = bytes[1];
        step();
        for (int i = 2; i < 10; i++) begin
            bif.byte_in = bytes[i];
            consume_n   = 5'd8;
            step();
            chk("b2b_win_valid", 32'(win_valid), 32'h1);
            chk("b2b_win", 32'(win), {16'h0, bytes[i-1], bytes[i]});
        end
        idle_inputs();
        chk("b2b_bits_consumed", 32'(bits_consumed), 32'd64);
    endtask

    task automatic test_async_reset();
        bif.byte_valid = 1'b1;
        bif.byte_in    = 8'h77;
        consume_n      = 5'd5;
        step();
        idle_inputs();
        #2 reset = 1'b1;
        #1;
        chk("ar_win", 32'(win), 32'h0);
        chk("ar_bit_count", 32'(bit_count), 32'd0);
        chk("ar_bits_consumed", 32'(bits_consumed), 32'd0);
        chk("ar_win_valid", 32'(win_valid), 32'h0);
        chk("ar_byte_ready", 32'(bif.byte_ready), 32'h1);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_prime();
        test_consume_ingest();
        test_align();
        test_flush_with_byte();
        test_backpressure();
        test_illegal();
        test_over_max_consume();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", nt, nf);
        $finish;
    end
endmodule

// File: doc/cabac_bit_feeder.md
# cabac_bit_feeder

Bitstream front-end for the CABAC arithmetic decoder. It accepts slice-data bytes from the upstream byte source over a valid/ready handshake and buffers them in a 32-bit MSB-first shift buffer. It presents the next 16 unconsumed bits as a window, from which the decoder core builds its `m_value` refill words on regular-bin renormalization and on multi-bin bypass. Each cycle the core returns how many bits it consumed (0..16). The feeder also supports slice flush and byte alignment.

## Interface
- `BUF_BITS`, 32: shift-buffer capacity in bits; must be 32 in this revision.
- `WIN_BITS`, 16: window width and maximum consume per cycle.
- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `byte_in`  in  8  upstream slice-data byte, bitstream order MSB first.
- `byte_valid`  in  1  `byte_in` is valid.
- `byte_ready`  out  1  feeder accepts a byte this cycle.
- `consume_n`  in  5  bits consumed by the decoder core this cycle; legal range 0..16.
- `align`  in  1  discard bits up to the next byte boundary, applied after consume.
- `flush`  in  1  synchronous clear of buffer and counters, e.g. at slice start.
- `win`  out  16  next 16 unconsumed bits; `win[15]` is the oldest bit.
- `win_valid`  out  1  at least 16 bits are buffered.
- `bit_count`  out  6  buffered bit count, 0..32.
- `bits_consumed`  out  24  running total of consumed bits; wraps modulo 2^24.
- `err`  out  1  sticky; set on an illegal consume.

## Operation
- **Storage.** `buf[31:0]` holds the unconsumed bits, left-aligned. Valid bits are `buf[31 -: cnt]`; all bits below them are zero. `win = buf[31:16]`.
- **Consume.** Legal iff `consume_n <= 16` and `consume_n <= cnt`.
  - Legal consume: `buf <<= consume_n`, `cnt -= consume_n`, `bits_consumed += consume_n`.
  - Illegal consume: no bits are consumed and `err` is set.
  - `consume_n = 0` is a no-op.
  - The core may consume while `win_valid = 0` if `consume_n <= cnt`. The zero-filled low window bits are don't-care for the core.
- **Align.** Applied after consume, using the post-consume count `c1`. With `d = c1 mod 8`: `buf <<= d`, `cnt = c1 - d`, `bits_consumed += d`. If `d = 0`, align is a no-op.
- **Ingest.** A byte is accepted when `byte_valid & byte_ready`.
  - With `c2` the count after consume and align, the byte is written at `buf[31-c2 -: 8]` and `cnt = c2 + 8`.
  - Ingest lands in the same cycle as consume and align.
- **Ordering within one cycle:** consume, then align, then ingest. Everything is computed from the registered state and committed at the clock edge.
- **`byte_ready = (cnt <= 24)`.** It is driven from the registered count only, with no combinational path from `consume_n` or `align`. This guarantees the buffer cannot overflow.
- **Flush.** Has priority over everything else. Sets `buf = 0`, `cnt = 0`, `bits_consumed = 0`, `err = 0`. No byte is accepted in the flush cycle: `byte_ready` is forced to 0 while `flush` is high.
- **Priming.**
  - After reset or flush, the feeder is in PRIME: `win_valid = 0` until `cnt >= 16`.
  - It then enters RUN: `win_valid = (cnt >= 16)`.
  - In RUN, `cnt < 16` is legal (a starved upstream). The core must stall, and the feeder makes no further state change from this condition.
  - The PRIME/RUN distinction is exported only through `win_valid`.

## Timing
- **Reset values:** `buf = 0`, `cnt = 0`, `byte_ready = 1`, `win = 0`, `win_valid = 0`, `bit_count = 0`, `bits_consumed = 0`, `err = 0`.
- **Latency.** A byte accepted at edge k is visible in `win` after edge k; `win_valid` rises in the cycle after the 2nd byte from empty. A consume at edge k is reflected in `win` in the following cycle.
- **Throughput.** Up to 1 byte in and 16 bits out per cycle. At 8 bits per cycle consumed, the feeder sustains `win_valid` continuously once primed.
- **All outputs are registered** or decoded from registered `cnt`/`buf` only.
- **Simultaneous events:**
  - Flush with anything else: only the flush takes effect.
  - Illegal consume together with align or ingest: align and ingest still proceed using the unchanged count.
  - `bits_consumed` wrap past 2^24−1 is silent.

## Structure
- **Shared package `cabac_pkg`:** `WIN_BITS`, `BUF_BITS`, `MAX_CONSUME = 16`, and the consume-count type `logic [4:0]`. The decoder core reuses the latter for `numBits`.
- **Sub-module `cabac_bit_buffer`:** the barrel shift plus byte insertion datapath, purely combinational, taking registered state in and producing next state out. The top level holds the registers, handshake, counters and error logic.

## Test plan
- **Prime:** reset, then feed `0x8C`, `0xD1` → `win_valid` rises after the 2nd accept, `win = 0x8CD1`, `bit_count = 16`.
- **Consume with ingest:** add `0x5A`, consume 3 → `win = 0x668A`, `bit_count = 21`, `bits_consumed = 3`.
- **Align:** from the previous state, `align = 1` with `consume_n = 0` → `bit_count = 16`, `win = 0xD15A`, `bits_consumed = 8`.
- **Backpressure:** hold `byte_valid = 1` with no consume → exactly 4 bytes accepted, `byte_ready = 0` at `bit_count = 32`; consume 16 → `byte_ready` returns to 1 the next cycle.
- **Illegal consume:** `bit_count = 5`, `consume_n = 7` → state unchanged, `err = 1` and stays set; flush → `err = 0`, `bit_count = 0`.
- **Mid-operation reset and flush:** assert `reset` asynchronously mid-stream → all outputs at reset values immediately. Flush together with `byte_valid` → byte not accepted, `bit_count = 0`.
